// File: rtl/axi_lite_master_interface.sv
// axi_lite_master_interface: user command to AXI4-Lite master bridge, one command in flight
//
// Ports:
//   ACLK, ARESETN            clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_write selects write (1) or read (0)
//   cmd_addr/wdata/wstrb     command payload (wdata/wstrb ignored for reads)
//   resp_valid/resp_ready    response handshake
//   resp_write/rdata/resp    response kind, read data (0 for writes), BRESP/RRESP
//   M_AXI_AW*/W*/B*/AR*/R*   AXI4-Lite master channels, all outputs registered
module axi_lite_master_interface #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic                              resp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_rdata,
    output logic [1:0]                        resp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RESP} state_t;
    state_t state, state_next;
    logic aw_done, w_done;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign cmd_ready    = (state == IDLE);
    // AW and W finish independently; a dropped VALID means that channel is done
    assign aw_done      = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done       = !M_AXI_WVALID || M_AXI_WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = cmd_write ? WR : RA;
            WR:      if (aw_done && w_done) state_next = WB;
            WB:      if (M_AXI_BVALID) state_next = RESP;
            RA:      if (M_AXI_ARREADY) state_next = RD;
            RD:      if (M_AXI_RVALID) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Level-type outputs are registered copies of the next state so they line up with it
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            resp_valid    <= 1'b0;
            resp_write    <= 1'b0;
            resp_rdata    <= '0;
            resp_resp     <= 2'b00;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_ARADDR  <= '0;
        end else begin
            M_AXI_ARVALID <= (state_next == RA);
            M_AXI_BREADY  <= (state_next == WB);
            M_AXI_RREADY  <= (state_next == RD);
            resp_valid    <= (state_next == RESP);
            if (state == IDLE && cmd_valid) begin
                if (cmd_write) begin
                    M_AXI_AWADDR  <= cmd_addr;
                    M_AXI_WDATA   <= cmd_wdata;
                    M_AXI_WSTRB   <= cmd_wstrb;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_WVALID  <= 1'b1;
                end else begin
                    M_AXI_ARADDR <= cmd_addr;
                end
            end
            if (state == WR) begin
                if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
            end
            if (state == WB && M_AXI_BVALID) begin
                resp_write <= 1'b1;
                resp_rdata <= '0;
                resp_resp  <= M_AXI_BRESP;
            end
            if (state == RD && M_AXI_RVALID) begin
                resp_write <= 1'b0;
                resp_rdata <= M_AXI_RDATA;
                resp_resp  <= M_AXI_RRESP;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_interface.sv
// tb_axi_lite_master_interface: randomized bench with a latency-programmable AXI-Lite slave model
//
// The slave model records every handshake and payload; expected responses, handshake
// counts and response latency are derived from the programmed slave behaviour.
module tb_axi_lite_master_interface;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_write;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    int n_checks = 0, n_err = 0;
    int k_aw, k_w, k_b, k_ar, k_r;
    logic [1:0] k_bresp, k_rresp;
    logic [31:0] k_rdata;
    int aw_n, w_n, b_n, ar_n, r_n, aw_vc, w_vc, ar_vc, viol;
    logic [31:0] aw_seen, w_seen, ar_seen;
    logic [3:0] ws_seen;
    int b_aw, b_w, b_b, b_ar, b_r, b_awc, b_wc, b_arc, b_viol;

    axi_lite_master_interface dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_resp(resp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Slave: READY after k_* cycles of VALID, B/R issued k_b/k_r cycles after the request completes.
    // Handshakes of a posedge are logged at the following negedge.
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, b_arm, r_arm, aw_pv, w_pv, ar_pv;
        logic [31:0] aw_pa, w_pd, ar_pa;
        logic [3:0] w_ps;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                {awready, wready, arready, bvalid, rvalid} = '0;
                {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, b_arm, r_arm, aw_pv, w_pv, ar_pv} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
            end else begin
                if (aw_pv && !aw_hs && !(awvalid && awaddr == aw_pa)) viol++;
                if (w_pv && !w_hs && !(wvalid && wdata == w_pd && wstrb == w_ps)) viol++;
                if (ar_pv && !ar_hs && !(arvalid && araddr == ar_pa)) viol++;
                if (aw_hs) begin aw_n++; aw_seen = aw_pa; aw_got = 1; aw_cnt = 0; end
                if (w_hs) begin w_n++; w_seen = w_pd; ws_seen = w_ps; w_got = 1; w_cnt = 0; end
                if (ar_hs) begin ar_n++; ar_seen = ar_pa; r_arm = 1; r_cnt = 0; ar_cnt = 0; end
                if (b_hs) begin b_n++; bvalid = 1'b0; end
                if (r_hs) begin r_n++; rvalid = 1'b0; end
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_arm = 1; b_cnt = 0; end
                if (b_arm && !bvalid) begin
                    if (b_cnt >= k_b) begin bvalid = 1'b1; bresp = k_bresp; b_arm = 0; end
                    else b_cnt++;
                end
                if (r_arm && !rvalid) begin
                    if (r_cnt >= k_r) begin rvalid = 1'b1; rdata = k_rdata; rresp = k_rresp; r_arm = 0; end
                    else r_cnt++;
                end
                if (awvalid) begin awready = (aw_cnt >= k_aw); aw_cnt++; aw_vc++; end
                else begin awready = 1'b0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= k_w); w_cnt++; w_vc++; end
                else begin wready = 1'b0; w_cnt = 0; end
                if (arvalid) begin arready = (ar_cnt >= k_ar); ar_cnt++; ar_vc++; end
                else begin arready = 1'b0; ar_cnt = 0; end
                aw_pv = awvalid; aw_pa = awaddr; aw_hs = awvalid && awready;
                w_pv = wvalid; w_pd = wdata; w_ps = wstrb; w_hs = wvalid && wready;
                ar_pv = arvalid; ar_pa = araddr; ar_hs = arvalid && arready;
                b_hs = bvalid && bready;
                r_hs = rvalid && rready;
            end
        end
    end

    task automatic knobs(input int aw, w, b, ar, r, input logic [1:0] br, rr, input logic [31:0] rd);
        k_aw = aw; k_w = w; k_b = b; k_ar = ar; k_r = r;
        k_bresp = br; k_rresp = rr; k_rdata = rd;
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, data, input logic [3:0] strb,
                         input bit keep, output int waited);
        b_aw = aw_n; b_w = w_n; b_b = b_n; b_ar = ar_n; b_r = r_n;
        b_awc = aw_vc; b_wc = w_vc; b_arc = ar_vc; b_viol = viol;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 50) begin @(negedge aclk); waited++; end
        check("cmd_accept", cmd_ready, 1'b1);
        @(negedge aclk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic finish_txn(input bit wr, input logic [31:0] addr, data, input logic [3:0] strb, input int hold);
        int n, lat;
        logic [34:0] snap;
        lat = wr ? 3 + (k_aw > k_w ? k_aw : k_w) + k_b : 3 + k_ar + k_r;
        n = 1;
        while (!resp_valid && n < 200) begin @(negedge aclk); n++; end
        check("resp_latency", n, lat);
        snap = {resp_write, resp_rdata, resp_resp};
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("resp_stall", {resp_valid, cmd_ready, awvalid, wvalid, arvalid, resp_write, resp_rdata, resp_resp},
                  {1'b1, 1'b0, 3'b000, snap});
        end
        check("resp_fields", {resp_valid, cmd_ready, resp_write, resp_rdata, resp_resp},
              {1'b1, 1'b0, wr, wr ? 32'd0 : k_rdata, wr ? k_bresp : k_rresp});
        check("handshake_counts", {8'(aw_n - b_aw), 8'(w_n - b_w), 8'(b_n - b_b), 8'(ar_n - b_ar), 8'(r_n - b_r)},
              wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
        if (wr) begin
            check("aw_w_payload", {aw_seen, w_seen, ws_seen}, {addr, data, strb});
            check("aw_w_valid_cycles", {8'(aw_vc - b_awc), 8'(w_vc - b_wc)}, {8'(k_aw + 1), 8'(k_w + 1)});
        end else begin
            check("ar_payload", ar_seen, addr);
            check("ar_valid_cycles", ar_vc - b_arc, k_ar + 1);
        end
        check("valid_hold_rule", viol - b_viol, 0);
        check("prot", {awprot, arprot}, 6'd0);
        resp_ready = 1'b1;
        @(negedge aclk);
        resp_ready = 1'b0;
        check("resp_release", {resp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1);
    end

    initial begin : main
        bit wr, seen;
        logic [31:0] a, d;
        logic [3:0] s;
        int waited;
        knobs(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
        repeat (3) @(negedge aclk);
        check("reset_outputs", {awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_write, resp_rdata, resp_resp}, '0);
        check("reset_payload", {awaddr, wdata, wstrb, araddr}, '0);
        check("reset_ready", {cmd_ready, awprot, arprot}, {1'b1, 6'd0});
        aresetn = 1'b1;
        @(negedge aclk);
        // minimum-latency write
        knobs(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, waited);
        finish_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        // AWREADY late, WREADY immediate
        knobs(3, 0, 0, 0, 0, 2'b01, 2'b00, 32'd0);
        issue(1'b1, 32'h44, 32'hA5A5_0F0F, 4'h3, 1'b0, waited);
        finish_txn(1'b1, 32'h44, 32'hA5A5_0F0F, 4'h3, 0);
        // read with slow ARREADY and SLVERR
        knobs(0, 0, 0, 2, 0, 2'b00, 2'b10, 32'h12345678);
        issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, waited);
        finish_txn(1'b0, 32'h24, 32'h0, 4'h0, 0);
        // response consumer stalls, then a read follows
        knobs(0, 2, 1, 0, 0, 2'b11, 2'b00, 32'h0);
        issue(1'b1, 32'h80, 32'h0BAD_F00D, 4'h5, 1'b0, waited);
        finish_txn(1'b1, 32'h80, 32'h0BAD_F00D, 4'h5, 5);
        knobs(0, 0, 0, 1, 2, 2'b00, 2'b01, 32'hCAFE_1234);
        issue(1'b0, 32'h84, 32'h0, 4'h0, 1'b0, waited);
        finish_txn(1'b0, 32'h84, 32'h0, 4'h0, 1);
        // reset while waiting on B with BVALID up
        knobs(0, 0, 1, 0, 0, 2'b00, 2'b00, 32'h0);
        issue(1'b1, 32'h90, 32'h1111_2222, 4'hF, 1'b0, waited);
        for (int i = 0; i < 20 && !(bvalid && bready); i++) begin @(negedge aclk); #1; end
        check("b_pending_before_reset", {bvalid, bready}, 2'b11);
        aresetn = 1'b0;
        @(negedge aclk);
        check("reset_mid_txn", {awvalid, wvalid, arvalid, bready, rready, resp_valid, cmd_ready}, 7'b0000001);
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(negedge aclk); seen |= resp_valid; end
        check("no_resp_after_reset", {seen, cmd_ready}, 2'b01);
        // write then read with cmd_valid held throughout
        knobs(1, 0, 0, 0, 0, 2'b00, 2'b00, 32'h7777_8888);
        issue(1'b1, 32'hA0, 32'h5555_6666, 4'h9, 1'b1, waited);
        cmd_write = 1'b0; cmd_addr = 32'hA4;
        finish_txn(1'b1, 32'hA0, 32'h5555_6666, 4'h9, 2);
        issue(1'b0, 32'hA4, 32'h0, 4'h0, 1'b0, waited);
        check("b2b_accept_wait", waited, 0);
        finish_txn(1'b0, 32'hA4, 32'h0, 4'h0, 0);
        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            knobs($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 2'($urandom), 2'($urandom), $urandom);
            wr = 1'($urandom);
            a = $urandom; d = $urandom; s = 4'($urandom);
            issue(wr, a, d, s, 1'b0, waited);
            finish_txn(wr, a, d, s, $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
